demux_vc: RTL and testbench

DEMUX_VC -- requirements
Module: demux_vc

---
 rtl/demux_vc.sv | 111 +++++++++++
 tb/tb_demux_vc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux_vc.sv
// demux_vc: 1-to-4 word demultiplexer with a single-word hold stage.
// The top two bits of each word select the destination; a paused
// destination parks the word in a hold register until its pause clears.
module demux_vc #(
    parameter int unsigned DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [3:0]        pause,
    output logic              stall,
    output logic [DATA_W-1:0] Out0,
    output logic [DATA_W-1:0] Out1,
    output logic [DATA_W-1:0] Out2,
    output logic [DATA_W-1:0] Out3,
    output logic [3:0]        push,
    output logic [7:0]        word_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [1:0]        hold_dest_q, hold_dest_d;
    logic [DATA_W-1:0] out_q [4];
    logic [DATA_W-1:0] out_d [4];
    logic [3:0]        push_q, push_d;
    logic [7:0]        word_count_q, word_count_d;

    logic [1:0]        in_dest;
    logic              accept;

    assign in_dest = data_in[DATA_W-1:DATA_W-2];

    // Input is refused while a word is held, while paused by mode, or in reset
    always_comb begin
        stall  = (fsm_q == HOLD) || !state || reset;
        accept = valid_in && !stall;
    end

    // Next-state: route the accepted word, park it, or release the held word
    always_comb begin
        fsm_d       = fsm_q;
        hold_data_d = hold_data_q;
        hold_dest_d = hold_dest_q;
        out_d       = out_q;
        push_d      = '0;

        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    if (!pause[in_dest]) begin
                        out_d[in_dest]  = data_in;
                        push_d[in_dest] = 1'b1;
                    end else begin
                        hold_data_d = data_in;
                        hold_dest_d = in_dest;
                        fsm_d       = HOLD;
                    end
                end
            end
            HOLD: begin
                // Release depends only on the held destination's pause, not on mode
                if (!pause[hold_dest_q]) begin
                    out_d[hold_dest_q]  = hold_data_q;
                    push_d[hold_dest_q] = 1'b1;
                    fsm_d               = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase

        word_count_d = word_count_q + {7'b0, |push_d};
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= IDLE;
            hold_data_q  <= '0;
            hold_dest_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
            push_q       <= '0;
            word_count_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            hold_data_q  <= hold_data_d;
            hold_dest_q  <= hold_dest_d;
            for (int unsigned i = 0; i < 4; i++) begin
                out_q[i] <= out_d[i];
            end
            push_q       <= push_d;
            word_count_q <= word_count_d;
        end
    end

    assign Out0       = out_q[0];
    assign Out1       = out_q[1];
    assign Out2       = out_q[2];
    assign Out3       = out_q[3];
    assign push       = push_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_demux_vc.sv
// Directed testbench for demux_vc with hand-computed expectations.
module tb_demux_vc;

    logic       clk;
    logic       reset;
    logic       state;
    logic       valid_in;
    logic [9:0] data_in;
    logic [3:0] pause;
    logic       stall;
    logic [9:0] Out0, Out1, Out2, Out3;
    logic [3:0] push;
    logic [7:0] word_count;

    int unsigned n_checks;
    int unsigned n_errors;

    demux_vc #(.DATA_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .pause      (pause),
        .stall      (stall),
        .Out0       (Out0),
        .Out1       (Out1),
        .Out2       (Out2),
        .Out3       (Out3),
        .push       (push),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streaming stimulus tables
    logic [9:0] s_data [4];
    logic [3:0] s_push [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        s_data[0] = 10'h0A5; s_push[0] = 4'b0001;
        s_data[1] = 10'h1C3; s_push[1] = 4'b0010;
        s_data[2] = 10'h2FF; s_push[2] = 4'b0100;
        s_data[3] = 10'h300; s_push[3] = 4'b1000;

        // Reset, with a word presented that must not be taken
        reset = 1'b1; state = 1'b1; valid_in = 1'b1; data_in = 10'h0B2; pause = 4'b0000;
        #1;
        check("rst_stall", stall, 1);
        tick();
        tick();
        check("rst_push", push, 4'b0000);
        check("rst_out0", Out0, 0);
        check("rst_out1", Out1, 0);
        check("rst_out2", Out2, 0);
        check("rst_out3", Out3, 0);
        check("rst_wc", word_count, 0);
        valid_in = 1'b0;
        reset = 1'b0;

        // Streaming to all four destinations
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = s_data[i];
            #1;
            check("stream_stall", stall, 0);
            tick();
            check("stream_push", push, s_push[i]);
        end
        valid_in = 1'b0;
        tick();
        check("stream_idle_push", push, 4'b0000);
        check("stream_out0", Out0, 10'h0A5);
        check("stream_out1", Out1, 10'h1C3);
        check("stream_out2", Out2, 10'h2FF);
        check("stream_out3", Out3, 10'h300);
        check("stream_wc", word_count, 4);

        // Backpressure on destination 2, with a dest-0 word waiting behind it
        pause = 4'b0100; valid_in = 1'b1; data_in = 10'h255;
        #1;
        check("bp_accept_stall", stall, 0);
        tick();
        data_in = 10'h0A1;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_stall", stall, 1);
            check("bp_hold_push", push, 4'b0000);
            tick();
        end
        pause = 4'b0000;
        #1;
        check("bp_release_stall", stall, 1);
        tick();
        check("bp_release_push", push, 4'b0100);
        check("bp_release_out2", Out2, 10'h255);
        check("bp_release_wc", word_count, 5);
        check("bp_after_stall", stall, 0);
        tick();
        check("bp_next_push", push, 4'b0001);
        check("bp_next_out0", Out0, 10'h0A1);
        check("bp_next_wc", word_count, 6);
        valid_in = 1'b0;

        // Mode gating
        state = 1'b0; valid_in = 1'b1; data_in = 10'h3C7;
        #1;
        check("mode_stall", stall, 1);
        tick();
        check("mode_push0", push, 4'b0000);
        tick();
        check("mode_push1", push, 4'b0000);
        state = 1'b1;
        #1;
        check("mode_resume_stall", stall, 0);
        tick();
        check("mode_push", push, 4'b1000);
        check("mode_out3", Out3, 10'h3C7);
        check("mode_wc", word_count, 7);
        valid_in = 1'b0;

        // Isolation: other destinations paused
        pause = 4'b1110; valid_in = 1'b1; data_in = 10'h011;
        #1;
        check("iso_stall", stall, 0);
        tick();
        check("iso_push", push, 4'b0001);
        check("iso_out0", Out0, 10'h011);
        check("iso_wc", word_count, 8);
        valid_in = 1'b0;
        pause = 4'b0000;

        // Reset while holding a word for destination 1
        pause = 4'b0010; valid_in = 1'b1; data_in = 10'h1AA;
        tick();
        valid_in = 1'b0;
        tick();
        check("rh_stall", stall, 1);
        check("rh_push", push, 4'b0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rh_out0", Out0, 0);
        check("rh_out1", Out1, 0);
        check("rh_out2", Out2, 0);
        check("rh_out3", Out3, 0);
        check("rh_wc", word_count, 0);
        pause = 4'b0000;
        #1;
        check("rh_stall_after", stall, 0);
        tick();
        check("rh_no_push0", push, 4'b0000);
        tick();
        check("rh_no_push1", push, 4'b0000);
        check("rh_out1_kept", Out1, 0);

        // Counter wrap over 256 back-to-back words
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            valid_in = 1'b1;
            data_in  = {lo[1:0], lo};
            tick();
            if (i == 254) check("wrap_wc_255", word_count, 255);
            if (i == 255) begin
                check("wrap_wc_0", word_count, 0);
                check("wrap_push", push, 4'b1000);
                check("wrap_out3", Out3, 10'h3FF);
            end
        end
        data_in = 10'h2AB;
        tick();
        check("wrap_wc_1", word_count, 1);
        check("wrap_out2", Out2, 10'h2AB);
        valid_in = 1'b0;
        tick();
        check("final_push", push, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
